// File: rtl/coin_state_ctrl_pkg.sv
// Shared state codes and amount helpers for the coin sequencer and the LED controller.
package coin_state_ctrl_pkg;

    localparam int STATE_W = 7;
    localparam int AMT_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 7'h01,
        ST_HALF     = 7'h02,
        ST_ONE      = 7'h04,
        ST_ONE_HALF = 7'h08,
        ST_TWO      = 7'h10,
        ST_TWO_HALF = 7'h21,
        ST_THREE    = 7'h41
    } coin_state_e;

    // Amounts are in half-yuan units.
    localparam logic [AMT_W-1:0] AMT_HALF = 3'd1;
    localparam logic [AMT_W-1:0] AMT_ONE  = 3'd2;
    localparam logic [AMT_W-1:0] PRICE    = 3'd5;
    localparam logic [AMT_W-1:0] MAX_AMT  = 3'd6;

    function automatic logic [AMT_W-1:0] state_amt(input logic [STATE_W-1:0] s);
        logic [AMT_W-1:0] a;
        a = 3'd0;
        case (s)
            ST_HALF:     a = 3'd1;
            ST_ONE:      a = 3'd2;
            ST_ONE_HALF: a = 3'd3;
            ST_TWO:      a = 3'd4;
            ST_TWO_HALF: a = 3'd5;
            ST_THREE:    a = 3'd6;
            default:     a = 3'd0;
        endcase
        return a;
    endfunction

    function automatic coin_state_e amt_state(input logic [AMT_W-1:0] a);
        coin_state_e s;
        s = ST_IDLE;
        case (a)
            3'd1:    s = ST_HALF;
            3'd2:    s = ST_ONE;
            3'd3:    s = ST_ONE_HALF;
            3'd4:    s = ST_TWO;
            3'd5:    s = ST_TWO_HALF;
            3'd6:    s = ST_THREE;
            default: s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/coin_state_ctrl_if.sv
// Coin inputs and LED/vend outputs of the coin sequencer.
// master drives coins and observes results; slave is the sequencer itself.
interface coin_state_ctrl_if;
    import coin_state_ctrl_pkg::*;

    logic               coin_half;
    logic               coin_one;
    logic [STATE_W-1:0] state;
    logic               vend;
    logic               change;
    logic               refund;
    logic [AMT_W-1:0]   refund_amt;
    logic               coin_reject;

    modport master (
        output coin_half, coin_one,
        input  state, vend, change, refund, refund_amt, coin_reject
    );

    modport slave (
        input  coin_half, coin_one,
        output state, vend, change, refund, refund_amt, coin_reject
    );
endinterface

// File: rtl/coin_state_ctrl_dwell_timer.sv
// Dwell counter with clear/enable; expired is high while the count equals tc.
// Latency: count updates one cycle after clr/en; expired is combinational on the count.
module dwell_timer #(
    parameter int CNT_W = 29
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == tc);

endmodule

// File: rtl/coin_state_ctrl.sv
// Coin accumulator FSM: coins add half-yuan units, vend/change/refund pulses, auto-return to IDLE.
// Latency: a coin at edge n updates state and pulses at edge n+1; no backpressure, rejects are flagged.
module coin_state_ctrl
    import coin_state_ctrl_pkg::*;
#(
    parameter int HOLD_CNT    = 150_000_000,
    parameter int TIMEOUT_CNT = 500_000_000,
    parameter int CNT_W       = 29
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    coin_state_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CNT - 1);

    coin_state_e        state_q, state_d;
    logic               vend_q, vend_d;
    logic               change_q, change_d;
    logic               refund_q, refund_d;
    logic [AMT_W-1:0]   refund_amt_q, refund_amt_d;
    logic               reject_q, reject_d;

    logic               coin_acc;
    logic [AMT_W-1:0]   cur_amt, add_amt, new_amt;
    logic               vend_state;
    logic               tmr_clr, tmr_expired;
    logic [CNT_W-1:0]   tmr_tc;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            vend_q       <= 1'b0;
            change_q     <= 1'b0;
            refund_q     <= 1'b0;
            refund_amt_q <= '0;
            reject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            vend_q       <= vend_d;
            change_q     <= change_d;
            refund_q     <= refund_d;
            refund_amt_q <= refund_amt_d;
            reject_q     <= reject_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vend_d       = 1'b0;
        change_d     = 1'b0;
        refund_d     = 1'b0;
        refund_amt_d = '0;
        reject_d     = 1'b0;
        coin_acc     = 1'b0;
        add_amt      = '0;
        cur_amt      = state_amt(state_q);
        new_amt      = cur_amt;

        case (state_q)
            ST_IDLE, ST_HALF, ST_ONE, ST_ONE_HALF, ST_TWO: begin
                // coin_one has priority; a simultaneous coin_half is bounced back
                if (bus.coin_one) begin
                    add_amt  = AMT_ONE;
                    coin_acc = 1'b1;
                    reject_d = bus.coin_half;
                end else if (bus.coin_half) begin
                    add_amt  = AMT_HALF;
                    coin_acc = 1'b1;
                end
                new_amt = cur_amt + add_amt;

                // A coin on the expiry cycle wins over the refund.
                if (coin_acc) begin
                    state_d  = amt_state(new_amt);
                    vend_d   = (new_amt >= PRICE);
                    change_d = (new_amt == MAX_AMT);
                end else if (state_q != ST_IDLE && tmr_expired) begin
                    state_d      = ST_IDLE;
                    refund_d     = 1'b1;
                    refund_amt_d = cur_amt;
                end
            end
            ST_TWO_HALF, ST_THREE: begin
                reject_d = bus.coin_half | bus.coin_one;
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign vend_state = (state_q == ST_TWO_HALF) || (state_q == ST_THREE);
    assign tmr_tc     = vend_state ? HOLD_TC : TIMEOUT_TC;
    assign tmr_clr    = coin_acc || (state_d != state_q) || (state_q == ST_IDLE);

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (tmr_clr),
        .en      (1'b1),
        .tc      (tmr_tc),
        .expired (tmr_expired)
    );

    assign bus.state       = state_q;
    assign bus.vend        = vend_q;
    assign bus.change      = change_q;
    assign bus.refund      = refund_q;
    assign bus.refund_amt  = refund_amt_q;
    assign bus.coin_reject = reject_q;

endmodule

// File: tb/tb_coin_state_ctrl.sv
// Directed bench for coin_state_ctrl with short hold/timeout values.
module tb_coin_state_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    coin_state_ctrl_if ifc ();

    coin_state_ctrl #(
        .HOLD_CNT    (20),
        .TIMEOUT_CNT (50),
        .CNT_W       (8)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (ifc)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a coin for one sampling edge, then land 1 ns after it.
    task automatic coin(input logic h, input logic o);
        ifc.coin_half = h;
        ifc.coin_one  = o;
        @(posedge sys_clk);
        #1;
        ifc.coin_half = 1'b0;
        ifc.coin_one  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        ifc.coin_half = 1'b0;
        ifc.coin_one  = 1'b0;
        #12;
        chk("rst_state",  32'(ifc.state), 32'h01);
        chk("rst_vend",   32'(ifc.vend), 32'd0);
        chk("rst_refund", 32'(ifc.refund), 32'd0);
        chk("rst_amt",    32'(ifc.refund_amt), 32'd0);
        chk("rst_reject", 32'(ifc.coin_reject), 32'd0);
        sys_rst = 1'b0;
        idle(2);

        // 1: 1 + 1 + 0.5 -> TWO_HALF, held 20 cycles
        coin(0, 1); chk("s1_one", 32'(ifc.state), 32'h04);
        idle(4);
        coin(0, 1); chk("s1_two", 32'(ifc.state), 32'h10);
        chk("s1_two_vend", 32'(ifc.vend), 32'd0);
        idle(4);
        coin(1, 0); chk("s1_2h", 32'(ifc.state), 32'h21);
        chk("s1_vend", 32'(ifc.vend), 32'd1);
        chk("s1_change", 32'(ifc.change), 32'd0);
        idle(1);  chk("s1_vend_off", 32'(ifc.vend), 32'd0);
        idle(18); chk("s1_hold19", 32'(ifc.state), 32'h21);
        idle(1);  chk("s1_hold20", 32'(ifc.state), 32'h01);
        chk("s1_no_refund", 32'(ifc.refund), 32'd0);

        // 2: three 1-yuan coins -> THREE with change
        coin(0, 1); chk("s2_one", 32'(ifc.state), 32'h04);
        coin(0, 1); chk("s2_two", 32'(ifc.state), 32'h10);
        coin(0, 1); chk("s2_three", 32'(ifc.state), 32'h41);
        chk("s2_vend", 32'(ifc.vend), 32'd1);
        chk("s2_change", 32'(ifc.change), 32'd1);
        idle(1);  chk("s2_change_off", 32'(ifc.change), 32'd0);
        idle(18); chk("s2_hold19", 32'(ifc.state), 32'h41);
        idle(1);  chk("s2_hold20", 32'(ifc.state), 32'h01);

        // 3: timeout refund, then coin on the expiry cycle
        coin(1, 0); chk("s3_half", 32'(ifc.state), 32'h02);
        idle(49); chk("s3_t49", 32'(ifc.state), 32'h02);
        chk("s3_t49_refund", 32'(ifc.refund), 32'd0);
        idle(1);  chk("s3_t50", 32'(ifc.state), 32'h01);
        chk("s3_refund", 32'(ifc.refund), 32'd1);
        chk("s3_amt", 32'(ifc.refund_amt), 32'd1);
        idle(1);  chk("s3_refund_off", 32'(ifc.refund), 32'd0);
        chk("s3_amt_off", 32'(ifc.refund_amt), 32'd0);
        coin(1, 0); chk("s3b_half", 32'(ifc.state), 32'h02);
        idle(49);
        coin(1, 0); chk("s3b_coin_wins", 32'(ifc.state), 32'h04);
        chk("s3b_no_refund", 32'(ifc.refund), 32'd0);
        idle(49); chk("s3b_t49", 32'(ifc.state), 32'h04);
        idle(1);  chk("s3b_t50", 32'(ifc.state), 32'h01);
        chk("s3b_refund", 32'(ifc.refund), 32'd1);
        chk("s3b_amt", 32'(ifc.refund_amt), 32'd2);
        idle(1);

        // 4: both coins together in IDLE and in TWO
        coin(1, 1); chk("s4_idle", 32'(ifc.state), 32'h04);
        chk("s4_reject", 32'(ifc.coin_reject), 32'd1);
        idle(1);  chk("s4_reject_off", 32'(ifc.coin_reject), 32'd0);
        coin(0, 1); chk("s4_two", 32'(ifc.state), 32'h10);
        coin(1, 1); chk("s4_three", 32'(ifc.state), 32'h41);
        chk("s4_vend", 32'(ifc.vend), 32'd1);
        chk("s4_change", 32'(ifc.change), 32'd1);
        chk("s4_reject2", 32'(ifc.coin_reject), 32'd1);
        idle(20); chk("s4_back", 32'(ifc.state), 32'h01);

        // 5: coin during hold is rejected and does not extend the hold
        coin(0, 1); coin(0, 1);
        coin(1, 0); chk("s5_2h", 32'(ifc.state), 32'h21);
        idle(9);
        coin(0, 1); chk("s5_reject", 32'(ifc.coin_reject), 32'd1);
        chk("s5_state", 32'(ifc.state), 32'h21);
        coin(1, 1); chk("s5_reject_both", 32'(ifc.coin_reject), 32'd1);
        idle(8);  chk("s5_hold19", 32'(ifc.state), 32'h21);
        idle(1);  chk("s5_hold20", 32'(ifc.state), 32'h01);

        // 6: async reset mid-accumulation discards the amount silently
        coin(0, 1); coin(1, 0); chk("s6_1h", 32'(ifc.state), 32'h08);
        #3 sys_rst = 1'b1;
        #1 chk("s6_async", 32'(ifc.state), 32'h01);
        chk("s6_no_refund", 32'(ifc.refund), 32'd0);
        idle(3);
        #2 sys_rst = 1'b0;
        idle(60); chk("s6_idle", 32'(ifc.state), 32'h01);
        chk("s6_still_no_refund", 32'(ifc.refund), 32'd0);
        coin(1, 0); chk("s6_half", 32'(ifc.state), 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
